// File: rtl/branch_update_scheduler_if.sv
// ----------------------------------------------------------------------------
// branch_update_scheduler_if
//
// Purpose: bundles every handshake and data signal between the branch update
// scheduler and its neighbours (fetch, the global-history predictor, execute)
// into one interface.
//
// Parameters:
//   PTR_W   log2 of the outstanding-prediction queue depth; count is PTR_W+1 wide
//
// Signals (direction as seen by the scheduler):
//   req_valid       in   fetch requests a prediction
//   req_ready       out  scheduler can accept a request this cycle
//   predict_valid   out  lookup strobe to the predictor
//   predict_result  in   predictor registered output, valid one cycle later
//   pred_out_valid  out  prediction returned to fetch
//   pred_out_taken  out  returned prediction (1 = taken)
//   resolve_valid   in   execute resolves the oldest outstanding branch
//   resolve_taken   in   actual branch outcome
//   flush           in   discard all outstanding predictions
//   renew_valid     out  registered update strobe to the predictor
//   last_predict    out  queued prediction of the resolved branch
//   renew_result    out  actual outcome of the resolved branch
//   mispredict      out  outcome differed from the queued prediction
//   count           out  number of outstanding predictions
//   underflow_err   out  sticky: resolve seen with an empty queue
//
// Modports:
//   master  the environment side (fetch + predictor + execute)
//   slave   the scheduler itself
// ----------------------------------------------------------------------------
interface branch_update_scheduler_if #(
    parameter int PTR_W = 2
);
    logic             req_valid;
    logic             req_ready;
    logic             predict_valid;
    logic             predict_result;
    logic             pred_out_valid;
    logic             pred_out_taken;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             flush;
    logic             renew_valid;
    logic             last_predict;
    logic             renew_result;
    logic             mispredict;
    logic [PTR_W:0]   count;
    logic             underflow_err;

    modport master (
        output req_valid,
        output predict_result,
        output resolve_valid,
        output resolve_taken,
        output flush,
        input  req_ready,
        input  predict_valid,
        input  pred_out_valid,
        input  pred_out_taken,
        input  renew_valid,
        input  last_predict,
        input  renew_result,
        input  mispredict,
        input  count,
        input  underflow_err
    );

    modport slave (
        input  req_valid,
        input  predict_result,
        input  resolve_valid,
        input  resolve_taken,
        input  flush,
        output req_ready,
        output predict_valid,
        output pred_out_valid,
        output pred_out_taken,
        output renew_valid,
        output last_predict,
        output renew_result,
        output mispredict,
        output count,
        output underflow_err
    );
endinterface

// File: rtl/branch_update_scheduler.sv
// ----------------------------------------------------------------------------
// branch_update_scheduler
//
// Purpose: sequences the global-history branch predictor between fetch and
// execute. A fetch request is granted as a one-cycle predictor lookup; the
// predictor's registered answer is returned to fetch and queued in order.
// When execute resolves the oldest branch, the queued prediction is popped
// and a registered renew update (prediction, outcome, mispredict flag) is
// sent back to the predictor on the following cycle. A flush discards every
// outstanding entry and aborts a lookup in progress.
//
// Parameters:
//   DEPTH   outstanding-prediction queue entries (power of 2, >= 2)
//   PTR_W   log2(DEPTH)
//
// Ports:
//   clk     single clock, rising edge
//   rst     asynchronous, active-high reset
//   bus     branch_update_scheduler_if.slave (see the interface file)
//
// Build option:
//   BRANCH_AUTO_FLUSH_EN  when defined, a mispredicting resolve also empties
//                         the remaining queue and aborts an in-progress
//                         lookup on the same edge, exactly as a flush does.
//                         Undefined (default): a mispredict only pulses the
//                         mispredict output.
// ----------------------------------------------------------------------------
module branch_update_scheduler #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    branch_update_scheduler_if.slave    bus
);

    // Two-state lookup sequencer: a granted request occupies the next cycle
    // while the predictor's registered result comes back.
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOOKUP = 1'b1;

    localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [0:0]       state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_nxt;
    logic [DEPTH-1:0] mem;

    logic head;
    logic accept;
    logic push;
    logic pop;
    logic mis_now;
    logic kill;

    logic renew_q;
    logic last_q;
    logic result_q;
    logic mis_q;
    logic uf_q;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    assign head    = mem[rd_ptr];
    assign accept  = bus.req_valid && bus.req_ready;
    // A resolve only pops when an entry existed at the start of the cycle;
    // a same-cycle push does not make an empty queue poppable.
    assign pop     = bus.resolve_valid && (count_q != '0);
    assign mis_now = head != bus.resolve_taken;

`ifdef BRANCH_AUTO_FLUSH_EN
    // A mispredicting resolve empties the queue and aborts any lookup.
    assign kill = pop && mis_now;
`else
    assign kill = 1'b0;
`endif

    // The lookup completes (and is queued) unless this edge discards it.
    assign push = (state == LOOKUP) && !bus.flush && !kill;

    assign bus.req_ready      = (state == IDLE) && (count_q < FULL) && !bus.flush;
    assign bus.predict_valid  = accept;
    assign bus.pred_out_valid = push;
    assign bus.pred_out_taken = push && bus.predict_result;

    assign bus.renew_valid    = renew_q;
    assign bus.last_predict   = last_q;
    assign bus.renew_result   = result_q;
    assign bus.mispredict     = mis_q;
    assign bus.count          = count_q;
    assign bus.underflow_err  = uf_q;

    // Queue occupancy and read pointer. A flush (or auto-flush) wins over
    // the pop: the pop's renew is still issued, but the queue ends empty
    // with the read pointer caught up to the write pointer.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        count_nxt  = count_q;
        rd_ptr_nxt = rd_ptr;
        if (bus.flush || kill) begin
            count_nxt  = '0;
            rd_ptr_nxt = wr_ptr;
        end else begin
            if (pop) begin
                rd_ptr_nxt = rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_nxt = count_q + CNT_ONE;
                2'b01:   count_nxt = count_q - CNT_ONE;
                default: count_nxt = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control state, pointers and registered renew outputs
    // ------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            renew_q  <= 1'b0;
            last_q   <= 1'b0;
            result_q <= 1'b0;
            mis_q    <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            // LOOKUP always returns to IDLE; a grant is only possible in IDLE.
            state   <= accept ? LOOKUP : IDLE;
            wr_ptr  <= push ? (wr_ptr + PTR_ONE) : wr_ptr;
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;

            // Renew fields are zero outside the pulse so the outputs stay
            // quiet between updates.
            renew_q  <= pop;
            last_q   <= pop && head;
            result_q <= pop && bus.resolve_taken;
            mis_q    <= pop && mis_now;

            if (bus.resolve_valid && (count_q == '0)) begin
                uf_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prediction storage
    // ------------------------------------------------------------------
    // NOTE: the storage array is not reset; an entry is only ever read after
    // it has been written, and count/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.predict_result;
        end
    end

endmodule

// File: tb/tb_branch_update_scheduler.sv
// ----------------------------------------------------------------------------
// tb_branch_update_scheduler
//
// Drives directed and randomized fetch/resolve/flush traffic into
// branch_update_scheduler. A reference model (a plain queue of predictions
// plus a "lookup pending" flag) predicts, per cycle, the combinational
// handshake values and pushes expected pred_out / renew events into
// scoreboard queues tagged with the cycle they are due. A separate monitor
// on the falling edge compares whatever the DUT presents against them.
// Honours BRANCH_AUTO_FLUSH_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_branch_update_scheduler;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    branch_update_scheduler_if #(.PTR_W(PTR_W)) bus ();

    branch_update_scheduler #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   due;
        logic taken;
    } pred_exp_t;

    typedef struct {
        int   due;
        logic last;
        logic result;
        logic mis;
    } renew_exp_t;

    pred_exp_t  exp_pred[$];
    renew_exp_t exp_renew[$];

    bit   model_q[$];
    bit   lookup_pending = 1'b0;
    bit   uf_model       = 1'b0;

    int   cyc     = 0;
    bit   mon_en  = 1'b0;
    logic exp_ready = 1'b0;
    logic exp_pv    = 1'b0;
    int   exp_cnt   = 0;
    logic exp_uf    = 1'b0;

    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, got, exp, cyc, $time);
        end
    endtask

    // One clock cycle of stimulus. Called just after a rising edge; applies
    // the inputs, advances the model across the coming edge, and returns
    // just after that edge.
    task automatic cycle(input logic rv, input logic pr, input logic resv,
                         input logic rest, input logic fl);
        bit head;
        bit mis;
        bit kill;
        cyc++;
        bus.req_valid      = rv;
        bus.predict_result = pr;
        bus.resolve_valid  = resv;
        bus.resolve_taken  = rest;
        bus.flush          = fl;

        exp_cnt   = model_q.size();
        exp_uf    = uf_model;
        exp_ready = !lookup_pending && (model_q.size() < DEPTH) && !fl;
        exp_pv    = rv && exp_ready;

        kill = fl;
        if (resv) begin
            if (model_q.size() > 0) begin
                head = model_q.pop_front();
                mis  = head != rest;
                exp_renew.push_back('{cyc + 1, head, rest, mis});
`ifdef BRANCH_AUTO_FLUSH_EN
                if (mis) kill = 1'b1;
`endif
            end else begin
                uf_model = 1'b1;
            end
        end
        if (lookup_pending && !kill) begin
            model_q.push_back(pr);
            exp_pred.push_back('{cyc, pr});
        end
        if (kill) model_q.delete();
        lookup_pending = exp_pv;

        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic r);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, r,    1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic t);
        cycle(1'b0, 1'b0, 1'b1, t, 1'b0);
    endtask

    // Asynchronous reset, entered mid-cycle; pending renews are dropped.
    task automatic do_reset();
        mon_en             = 1'b0;
        bus.req_valid      = 1'b0;
        bus.predict_result = 1'b0;
        bus.resolve_valid  = 1'b0;
        bus.resolve_taken  = 1'b0;
        bus.flush          = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_count",          bus.count,          0);
        check("rst_renew_valid",    bus.renew_valid,    0);
        check("rst_mispredict",     bus.mispredict,     0);
        check("rst_pred_out_valid", bus.pred_out_valid, 0);
        check("rst_predict_valid",  bus.predict_valid,  0);
        check("rst_underflow_err",  bus.underflow_err,  0);
        exp_pred.delete();
        exp_renew.delete();
        model_q.delete();
        lookup_pending = 1'b0;
        uf_model       = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", bus.req_ready, 1);
        check("post_rst_count",     bus.count,     0);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    pred_exp_t  pe;
    renew_exp_t re;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("req_ready",     bus.req_ready,     exp_ready);
            check("predict_valid", bus.predict_valid, exp_pv);
            check("count",         bus.count,         exp_cnt);
            check("underflow_err", bus.underflow_err, exp_uf);

            if (exp_pred.size() > 0 && exp_pred[0].due == cyc) begin
                pe = exp_pred.pop_front();
                check("pred_out_valid", bus.pred_out_valid, 1);
                check("pred_out_taken", bus.pred_out_taken, pe.taken);
            end else begin
                check("pred_out_valid_idle", bus.pred_out_valid, 0);
            end

            if (exp_renew.size() > 0 && exp_renew[0].due == cyc) begin
                re = exp_renew.pop_front();
                check("renew_valid",  bus.renew_valid,  1);
                check("last_predict", bus.last_predict, re.last);
                check("renew_result", bus.renew_result, re.result);
                check("mispredict",   bus.mispredict,   re.mis);
            end else begin
                check("renew_valid_idle", bus.renew_valid, 0);
                check("mispredict_idle",  bus.mispredict,  0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bus.req_valid      = 1'b0;
        bus.predict_result = 1'b0;
        bus.resolve_valid  = 1'b0;
        bus.resolve_taken  = 1'b0;
        bus.flush          = 1'b0;
        #1;
        do_reset();

        // Single lookup returning taken.
        lookup(1'b1);
        // Queue [1,0], then two taken resolves: hit, then mispredict.
        lookup(1'b0);
        resolve(1'b1);
        resolve(1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Fill to DEPTH with req_valid held, then resolve while requesting.
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cycle(1'b1, k[0], 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush during a lookup with three entries, resolve in the same cycle.
        do_reset();
        lookup(1'b1);
        lookup(1'b0);
        lookup(1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Resolve with an empty queue: no renew, sticky underflow.
        resolve(1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        lookup(1'b1);

        // Queue [0,1,1], taken resolve mispredicts the head.
        do_reset();
        lookup(1'b0);
        lookup(1'b1);
        lookup(1'b1);
        resolve(1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with a mid-run reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle($urandom_range(0, 99) < 60,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 35,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 4);
        end

        // Drain so every scheduled event falls due.
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pred_events_left",  exp_pred.size(),  0);
        check("renew_events_left", exp_renew.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
